// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_ctrl_pkg
// Brief  : Shared encodings for the multicycle RISC-V control unit.
// Rev    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_FETCH  = 3'b001,
      ST_DECODE = 3'b010,
      ST_EXEC   = 3'b011,
      ST_MEM    = 3'b100,
      ST_WB     = 3'b101,
      ST_TRAP   = 3'b111
   } state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
      CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
   } opclass_t;

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_i      = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;

   localparam logic [1:0] c_a_rs1   = 2'b00;
   localparam logic [1:0] c_a_pc    = 2'b01;
   localparam logic [1:0] c_a_zero  = 2'b10;
   localparam logic [1:0] c_b_rs2   = 2'b00;
   localparam logic [1:0] c_b_imm   = 2'b01;
   localparam logic [1:0] c_b_four  = 2'b10;

   localparam logic [1:0] c_alu_add = 2'b00;
   localparam logic [1:0] c_alu_br  = 2'b01;
   localparam logic [1:0] c_alu_r   = 2'b10;
   localparam logic [1:0] c_alu_i   = 2'b11;

   localparam logic [1:0] c_m2r_alu = 2'b00;
   localparam logic [1:0] c_m2r_mem = 2'b01;
   localparam logic [1:0] c_m2r_pc4 = 2'b10;

   localparam logic [1:0] c_fault_none    = 2'b00;
   localparam logic [1:0] c_fault_illegal = 2'b01;
   localparam logic [1:0] c_fault_timeout = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic       instr_done;
   } ctrl_t;

   function automatic opclass_t op_class(input logic [6:0] op);
      opclass_t cls;
      case (op)
         c_op_r:      cls = CLS_R;
         c_op_i:      cls = CLS_I;
         c_op_load:   cls = CLS_LOAD;
         c_op_store:  cls = CLS_STORE;
         c_op_branch: cls = CLS_BRANCH;
         c_op_lui:    cls = CLS_LUI;
         c_op_auipc:  cls = CLS_AUIPC;
         c_op_jal:    cls = CLS_JAL;
         c_op_jalr:   cls = CLS_JALR;
         default:     cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_out_decode.sv
`default_nettype none
// ============================================================================
// Module : mc_out_decode
// Brief  : Combinational state/opcode to datapath-control decode.
// Rev    : 1.0 - initial release
// ============================================================================
module mc_out_decode
   import riscv_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   output ctrl_t      ctrl
);

   opclass_t w_cls;

   assign w_cls = op_class(opcode);

   // FETCH write strobes and MEM completion are qualified by mem_ready in the top
   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_a = c_a_pc;
            ctrl.alu_src_b = c_b_four;
            ctrl.alu_op    = c_alu_add;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
         end
         ST_DECODE: begin
            ctrl.alu_src_a = c_a_pc;
            ctrl.alu_src_b = c_b_imm;
         end
         ST_EXEC: begin
            case (w_cls)
               CLS_R: begin
                  ctrl.alu_src_a = c_a_rs1;
                  ctrl.alu_src_b = c_b_rs2;
                  ctrl.alu_op    = c_alu_r;
               end
               CLS_I: begin
                  ctrl.alu_src_a = c_a_rs1;
                  ctrl.alu_src_b = c_b_imm;
                  ctrl.alu_op    = c_alu_i;
               end
               CLS_LOAD, CLS_STORE: begin
                  ctrl.alu_src_a = c_a_rs1;
                  ctrl.alu_src_b = c_b_imm;
                  ctrl.alu_op    = c_alu_add;
               end
               CLS_LUI: begin
                  ctrl.alu_src_a = c_a_zero;
                  ctrl.alu_src_b = c_b_imm;
               end
               CLS_AUIPC: begin
                  ctrl.alu_src_a = c_a_pc;
                  ctrl.alu_src_b = c_b_imm;
               end
               CLS_BRANCH: begin
                  ctrl.alu_src_a  = c_a_rs1;
                  ctrl.alu_src_b  = c_b_rs2;
                  ctrl.alu_op     = c_alu_br;
                  ctrl.pc_write   = branch_taken;
                  ctrl.pc_src     = branch_taken;
                  ctrl.instr_done = 1'b1;
               end
               CLS_JAL: begin
                  ctrl.pc_src   = 1'b1;
                  ctrl.pc_write = 1'b1;
               end
               CLS_JALR: begin
                  ctrl.alu_src_a = c_a_rs1;
                  ctrl.alu_src_b = c_b_imm;
                  ctrl.pc_write  = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         ST_MEM: begin
            ctrl.mem_req      = 1'b1;
            ctrl.mem_addr_sel = 1'b1;
            ctrl.mem_we       = (w_cls == CLS_STORE);
            ctrl.instr_done   = (w_cls == CLS_STORE);
         end
         ST_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            if (w_cls == CLS_LOAD)
               ctrl.mem_to_reg = c_m2r_mem;
            else if (w_cls == CLS_JAL || w_cls == CLS_JALR)
               ctrl.mem_to_reg = c_m2r_pc4;
            else
               ctrl.mem_to_reg = c_m2r_alu;
         end
         default: ctrl = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multicycle RISC-V control FSM with memory-wait timeout and faults.
// Rev    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [1:0] mem_to_reg,
   output logic       instr_done,
   output logic [1:0] fault,
   output logic [2:0] state
);

   localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);

   state_t             r_state;
   logic [6:0]         r_opcode;
   logic [1:0]         r_fault;
   logic [c_cnt_w-1:0] r_wait_cnt;
   ctrl_t              w_ctrl;
   logic               w_fetch;
   logic               w_mem;
   logic               w_wait;
   logic               w_timeout;
   opclass_t           w_dec_cls;
   opclass_t           w_lat_cls;

   mc_out_decode u_out_decode (
      .state        (r_state),
      .opcode       (r_opcode),
      .branch_taken (branch_taken),
      .ctrl         (w_ctrl)
   );

   assign w_fetch   = (r_state == ST_FETCH);
   assign w_mem     = (r_state == ST_MEM);
   assign w_wait    = w_ctrl.mem_req & ~mem_ready;
   // The wait that would be the MEM_TIMEOUT-th consecutive one leaves for TRAP
   assign w_timeout = w_wait && (r_wait_cnt == c_cnt_w'(MEM_TIMEOUT - 1));
   assign w_dec_cls = op_class(opcode);
   assign w_lat_cls = op_class(r_opcode);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_opcode   <= '0;
         r_fault    <= c_fault_none;
         r_wait_cnt <= '0;
      end else begin
         if (w_wait && !w_timeout)
            r_wait_cnt <= r_wait_cnt + 1'b1;
         else
            r_wait_cnt <= '0;

         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (mem_ready)
                  r_state <= ST_DECODE;
               else if (w_timeout) begin
                  r_state <= ST_TRAP;
                  r_fault <= c_fault_timeout;
               end
            end
            ST_DECODE: begin
               r_opcode <= opcode;
               if (w_dec_cls == CLS_ILLEGAL) begin
                  r_state <= ST_TRAP;
                  r_fault <= c_fault_illegal;
               end else
                  r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               case (w_lat_cls)
                  CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
                  CLS_BRANCH:          r_state <= ST_FETCH;
                  default:             r_state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready)
                  r_state <= (w_lat_cls == CLS_STORE) ? ST_FETCH : ST_WB;
               else if (w_timeout) begin
                  r_state <= ST_TRAP;
                  r_fault <= c_fault_timeout;
               end
            end
            ST_WB:   r_state <= ST_FETCH;
            ST_TRAP: r_state <= ST_TRAP;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req      = w_ctrl.mem_req;
   assign mem_we       = w_ctrl.mem_we;
   assign mem_addr_sel = w_ctrl.mem_addr_sel;
   assign ir_write     = w_ctrl.ir_write & mem_ready;
   assign pc_write     = w_ctrl.pc_write & (~w_fetch | mem_ready);
   assign pc_src       = w_ctrl.pc_src;
   assign alu_src_a    = w_ctrl.alu_src_a;
   assign alu_src_b    = w_ctrl.alu_src_b;
   assign alu_op       = w_ctrl.alu_op;
   assign reg_write    = w_ctrl.reg_write;
   assign mem_to_reg   = w_ctrl.mem_to_reg;
   assign instr_done   = w_ctrl.instr_done & (~w_mem | mem_ready);
   assign fault        = r_fault;
   assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       branch_taken;
   logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
   logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg, fault;
   logic       reg_write, instr_done;
   logic [2:0] state;

   int n_total = 0;
   int n_bad   = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .reg_write    (reg_write),
      .mem_to_reg   (mem_to_reg),
      .instr_done   (instr_done),
      .fault        (fault),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs changed afterwards land well before the next edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // All control outputs concatenated, for the "everything zero" checks
   function automatic logic [31:0] all_ctrl();
      return 32'({mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done});
   endfunction

   initial begin
      rst = 1'b1; opcode = 7'b0; mem_ready = 1'b1; branch_taken = 1'b0;
      tick(); tick();
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_ctrl",  all_ctrl(), 0);

      // Scenario 1: R-type with zero-wait memory
      rst = 1'b0; opcode = 7'b0110011;
      #1;
      chk("s1_c1_idle", 32'(state), 0);
      chk("s1_idle_ctrl", all_ctrl(), 0);
      tick(); #1;
      chk("s1_c2_fetch", 32'(state), 1);
      chk("s1_fetch_sig", 32'({mem_req, mem_addr_sel, ir_write, pc_write, pc_src,
                               alu_src_a, alu_src_b, alu_op}), 32'b1_0_1_1_0_01_10_00);
      tick(); #1;
      chk("s1_c3_decode", 32'(state), 2);
      chk("s1_decode_ab", 32'({alu_src_a, alu_src_b}), 32'b01_01);
      tick(); #1;
      chk("s1_c4_exec", 32'(state), 3);
      chk("s1_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_00_10);
      chk("s1_exec_nodone", 32'(instr_done), 0);
      tick(); #1;
      chk("s1_c5_wb", 32'(state), 5);
      chk("s1_wb_sig", 32'({reg_write, mem_to_reg, instr_done}), 32'b1_00_1);

      // Scenario 2: LOAD with three wait cycles in MEM
      tick(); opcode = 7'b0000011; #1;
      chk("s2_fetch", 32'(state), 1);
      tick(); tick(); #1;
      chk("s2_exec", 32'({state, alu_src_a, alu_src_b, alu_op}), 32'b011_00_01_00);
      for (int i = 0; i < 4; i++) begin
         tick(); mem_ready = (i == 3); #1;
         chk($sformatf("s2_mem%0d_state", i), 32'(state), 4);
         chk($sformatf("s2_mem%0d_sig", i),
             32'({mem_req, mem_addr_sel, mem_we, instr_done, reg_write}), 32'b1_1_0_0_0);
      end
      tick(); #1;
      chk("s2_wb", 32'({state, reg_write, mem_to_reg, instr_done}), 32'b101_1_01_1);

      // Scenario 3: BRANCH taken then not taken, three cycles each
      tick(); opcode = 7'b1100011; branch_taken = 1'b1; #1;
      chk("s3t_fetch", 32'(state), 1);
      tick(); tick(); #1;
      chk("s3t_exec", 32'({state, pc_write, pc_src, alu_op, instr_done}), 32'b011_1_1_01_1);
      chk("s3t_noreg", 32'(reg_write), 0);
      tick(); branch_taken = 1'b0; #1;
      chk("s3n_fetch", 32'(state), 1);
      tick(); #1;
      chk("s3n_decode_nopc", 32'({state, pc_write}), 32'b010_0);
      tick(); #1;
      chk("s3n_exec", 32'({state, pc_write, pc_src, alu_op, instr_done}), 32'b011_0_0_01_1);
      tick(); #1;
      chk("s3n_back_fetch", 32'(state), 1);

      // JAL: PC from ALU-out in EXEC, PC+4 written back
      opcode = 7'b1101111;
      tick(); tick(); #1;
      chk("jal_exec", 32'({state, pc_write, pc_src}), 32'b011_1_1);
      tick(); #1;
      chk("jal_wb", 32'({state, reg_write, mem_to_reg}), 32'b101_1_10);

      // Scenario 4: illegal opcode traps after DECODE
      tick(); opcode = 7'b1111111; #1;
      chk("s4_fetch", 32'(state), 1);
      tick(); #1;
      chk("s4_decode", 32'({state, reg_write, pc_write, ir_write, mem_we}), 32'b010_0000);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk($sformatf("s4_trap%0d", i), 32'({state, fault}), 32'b111_01);
         chk($sformatf("s4_trap%0d_ctrl", i), all_ctrl(), 0);
      end

      // Scenario 5: FETCH timeout after four consecutive waits
      rst = 1'b1; #1;
      chk("s5_rst_clears_fault", 32'({state, fault}), 0);
      rst = 1'b0; mem_ready = 1'b0; opcode = 7'b0110011;
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("s5_wait%0d", i), 32'({state, ir_write, pc_write, mem_req}), 32'b001_0_0_1);
         tick();
      end
      #1;
      chk("s5_trap", 32'({state, fault}), 32'b111_10);
      chk("s5_trap_ctrl", all_ctrl(), 0);

      // Scenario 6: completed STORE, then reset mid-MEM of a second STORE
      rst = 1'b1; #1; rst = 1'b0; mem_ready = 1'b1; opcode = 7'b0100011;
      tick(); tick(); tick(); #1;
      chk("s6_exec", 32'({state, alu_src_b, alu_op}), 32'b011_01_00);
      tick(); #1;
      chk("s6_mem_done", 32'({state, mem_req, mem_we, mem_addr_sel, instr_done, reg_write}),
          32'b100_1_1_1_1_0);
      tick(); #1;
      chk("s6_store_to_fetch", 32'(state), 1);
      tick(); tick(); tick(); mem_ready = 1'b0; #1;
      chk("s6_mem_stall", 32'({state, mem_req, mem_we, instr_done}), 32'b100_1_1_0);
      tick(); #1;
      rst = 1'b1; #1;
      chk("s6_rst_async", 32'({state, mem_req, mem_we, fault}), 0);
      chk("s6_rst_ctrl", all_ctrl(), 0);
      tick(); rst = 1'b0; mem_ready = 1'b1; #1;
      chk("s6_idle", 32'(state), 0);
      tick(); #1;
      chk("s6_refetch", 32'({state, fault}), 32'b001_00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
